jk_ff: RTL and testbench



---
 rtl/jk_ff.sv | 35 +++
 tb/tb_jk_ff.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/jk_ff.sv
// rtl/jk_ff.sv - parameterizable bank of independent JK flip-flops with synchronous reset
module jk_ff #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH-1:0] q_next;

  // Per-bit JK next state: set where j and not q, keep where q and not k.
  // Written as the plain equation so X on j/k propagates without masking.
  always_comb begin
    q_next = (j & ~q) | (~k & q);
  end

  // State register; reset wins over j/k and is only seen on the rising edge.
  // No initial value, so q stays undefined until reset or a set/reset command.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= q_next;
    end
  end

  // Complement output is derived from q, never registered separately.
  assign q_n = ~q;

endmodule

// File: tb/tb_jk_ff.sv
// tb/tb_jk_ff.sv - self-checking scoreboard bench for jk_ff
module tb_jk_ff;

  logic       clk = 1'b0;
  logic       rst1;
  logic [0:0] j1, k1, q1, qn1;
  logic       rst4;
  logic [3:0] j4, k4, q4, qn4;

  int passed = 0;
  int total  = 0;

  logic [0:0] m1;
  logic [3:0] m4;
  logic [0:0] sb1[$];
  logic [3:0] sb4[$];

  always #20 clk = ~clk;

  jk_ff #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .j   (j1),
    .k   (k1),
    .q   (q1),
    .q_n (qn1)
  );

  jk_ff #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
    .clk (clk),
    .rst (rst4),
    .j   (j4),
    .k   (k4),
    .q   (q4),
    .q_n (qn4)
  );

  // Reference JK behaviour as a truth table, one bit at a time.
  function automatic logic nb(input logic cur, input logic jj, input logic kk);
    case ({jj, kk})
      2'b00:   nb = cur;
      2'b01:   nb = 1'b0;
      2'b10:   nb = 1'b1;
      default: nb = ~cur;
    endcase
  endfunction

  // Drive one edge on the 1-bit instance and push the expected q.
  task automatic apply1(input logic r, input logic jj, input logic kk);
    rst1 = r;
    j1   = jj;
    k1   = kk;
    if (r) m1 = 1'b0;
    else   m1 = nb(m1[0], jj, kk);
    sb1.push_back(m1);
    @(posedge clk);
    #1;
  endtask

  // Drive one edge on the 4-bit instance and push the expected q.
  task automatic apply4(input logic r, input logic [3:0] jj, input logic [3:0] kk);
    rst4 = r;
    j4   = jj;
    k4   = kk;
    if (r) m4 = 4'b1010;
    else   for (int b = 0; b < 4; b++) m4[b] = nb(m4[b], jj[b], kk[b]);
    sb4.push_back(m4);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [0:0] e;
    apply1(1'b1, 1'bx, 1'bx);
    e = sb1.pop_front();
    total++; if (q1 !== e)   $display("FAIL reset_x_q: q=%b expected %b", q1, e);    else passed++;
    total++; if (qn1 !== ~e) $display("FAIL reset_x_qn: q_n=%b expected %b", qn1, ~e); else passed++;
    for (int i = 0; i < 2; i++) begin
      apply1(1'b1, 1'b1, 1'b1);
      e = sb1.pop_front();
      total++; if (q1 !== e) $display("FAIL reset_hold_q%0d: q=%b expected %b", i, q1, e); else passed++;
    end
  endtask

  task automatic test_set_hold_reset();
    logic [0:0] e;
    logic [1:0] stim [6] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    apply1(1'b1, 1'b0, 1'b0);
    void'(sb1.pop_front());
    for (int i = 0; i < 6; i++) begin
      apply1(1'b0, stim[i][1], stim[i][0]);
      e = sb1.pop_front();
      total++; if (q1 !== e) $display("FAIL shr_q%0d: q=%b expected %b", i, q1, e); else passed++;
    end
  endtask

  task automatic test_toggle();
    logic [0:0] e;
    apply1(1'b1, 1'b0, 1'b0);
    void'(sb1.pop_front());
    for (int i = 0; i < 4; i++) begin
      apply1(1'b0, 1'b1, 1'b1);
      e = sb1.pop_front();
      total++; if (q1 !== e)   $display("FAIL toggle_q%0d: q=%b expected %b", i, q1, e);    else passed++;
      total++; if (qn1 !== ~e) $display("FAIL toggle_qn%0d: q_n=%b expected %b", i, qn1, ~e); else passed++;
    end
  endtask

  task automatic test_sample_point();
    logic [0:0] e;
    apply1(1'b1, 1'b0, 1'b0);
    void'(sb1.pop_front());
    // j=1 early in the cycle then withdrawn, plus a pulse wholly between edges.
    rst1 = 1'b0; j1 = 1'b1; k1 = 1'b0;
    #9  j1 = 1'b0;
    #10 j1 = 1'b1;
    #10 j1 = 1'b0;
    m1 = nb(m1[0], 1'b0, 1'b0);
    sb1.push_back(m1);
    @(posedge clk); #1;
    e = sb1.pop_front();
    total++; if (q1 !== e) $display("FAIL sample_pulse: q=%b expected %b", q1, e); else passed++;
    // j raised mid-cycle and held across the edge.
    j1 = 1'b0; k1 = 1'b0;
    #10 j1 = 1'b1;
    m1 = nb(m1[0], 1'b1, 1'b0);
    sb1.push_back(m1);
    @(posedge clk); #1;
    e = sb1.pop_front();
    total++; if (q1 !== e) $display("FAIL sample_late_set: q=%b expected %b", q1, e); else passed++;
  endtask

  task automatic test_reset_mid_sequence();
    logic [0:0] e;
    apply1(1'b0, 1'b1, 1'b1);
    void'(sb1.pop_front());
    apply1(1'b0, 1'b1, 1'b0);
    e = sb1.pop_front();
    total++; if (q1 !== e) $display("FAIL mid_pre: q=%b expected %b", q1, e); else passed++;
    apply1(1'b1, 1'b1, 1'b1);
    e = sb1.pop_front();
    total++; if (q1 !== e) $display("FAIL mid_reset: q=%b expected %b", q1, e); else passed++;
    apply1(1'b0, 1'b1, 1'b0);
    e = sb1.pop_front();
    total++; if (q1 !== e) $display("FAIL mid_release: q=%b expected %b", q1, e); else passed++;
  endtask

  task automatic test_multi_bit();
    logic [3:0] e;
    apply4(1'b1, 4'b0000, 4'b0000);
    e = sb4.pop_front();
    total++; if (q4 !== e)   $display("FAIL multi_reset: q=%b expected %b", q4, e);    else passed++;
    total++; if (qn4 !== ~e) $display("FAIL multi_reset_qn: q_n=%b expected %b", qn4, ~e); else passed++;
    for (int i = 0; i < 2; i++) begin
      apply4(1'b0, 4'b0011, 4'b0101);
      e = sb4.pop_front();
      total++; if (q4 !== e)   $display("FAIL multi_q%0d: q=%b expected %b", i, q4, e);    else passed++;
      total++; if (qn4 !== ~e) $display("FAIL multi_qn%0d: q_n=%b expected %b", i, qn4, ~e); else passed++;
    end
  endtask

  initial begin
    rst1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
    rst4 = 1'b1; j4 = 4'b0; k4 = 4'b0;
    @(posedge clk); #1;
    test_reset();
    test_set_hold_reset();
    test_toggle();
    test_sample_point();
    test_reset_mid_sequence();
    test_multi_bit();
    total++;
    if (sb1.size() != 0 || sb4.size() != 0)
      $display("FAIL scoreboard_drain: left %0d/%0d expected 0/0", sb1.size(), sb4.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t expected finish before 100000", $time);
    $fatal(1);
  end

endmodule
